// File: rtl/sr_alu_arb_pkg.sv
// Shared ALU opcodes, arbiter FSM states and the stall-counter type.
package sr_alu_arb_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_SRL  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    SR_ARB_IDLE = 2'b00,
    SR_ARB_EXEC = 2'b01,
    SR_ARB_RESP = 2'b10
  } arb_state_e;

  // Multiply stall counter; wide enough for the 0..15 latency range.
  typedef logic [3:0] cnt_t;

endpackage

// File: rtl/sr_alu_arb_if.sv
// Request/response channels of the two ALU requesters plus the shared result bus.
interface sr_alu_arb_if;
  logic        req_valid_0;
  logic        req_ready_0;
  logic [31:0] req_srcA_0;
  logic [31:0] req_srcB_0;
  logic [2:0]  req_oper_0;
  logic        req_valid_1;
  logic        req_ready_1;
  logic [31:0] req_srcA_1;
  logic [31:0] req_srcB_1;
  logic [2:0]  req_oper_1;
  logic        rsp_valid_0;
  logic        rsp_ready_0;
  logic        rsp_valid_1;
  logic        rsp_ready_1;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  // Requester side.
  modport master (
    output req_valid_0, req_srcA_0, req_srcB_0, req_oper_0,
    output req_valid_1, req_srcA_1, req_srcB_1, req_oper_1,
    output rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
    input  rsp_result, rsp_zero
  );

  // Arbiter side.
  modport slave (
    input  req_valid_0, req_srcA_0, req_srcB_0, req_oper_0,
    input  req_valid_1, req_srcA_1, req_srcB_1, req_oper_1,
    input  rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
    output rsp_result, rsp_zero
  );
endinterface

// File: rtl/sr_alu_arb_alu.sv
// Combinational 32-bit ALU; unused opcodes fall back to ADD.
module sr_alu
  import sr_alu_arb_pkg::*;
(
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [2:0]  oper,
  output logic        zero,
  output logic [31:0] result
);

  // Operation select and zero detect.
  always_comb begin
    result = srcA + srcB;
    case (oper)
      ALU_OR:   result = srcA | srcB;
      ALU_SRL:  result = srcA >> srcB[4:0];
      ALU_SLTU: result = {31'b0, (srcA < srcB)};
      ALU_SUB:  result = srcA - srcB;
      ALU_MUL:  result = srcA * srcB;
      default:  result = srcA + srcB;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/sr_alu_arb.sv
// Round-robin arbiter sharing one sr_alu between two requesters,
// with registered operands, registered result and an optional multiply stall.
module sr_alu_arb
  import sr_alu_arb_pkg::*;
#(
  parameter int unsigned MUL_LAT = 0,
  parameter bit          RR_INIT = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  sr_alu_arb_if.slave    bus
);

  localparam cnt_t MUL_CNT = cnt_t'(MUL_LAT);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_valid_0_q, rsp_valid_0_d;
  logic        rsp_valid_1_q, rsp_valid_1_d;

  logic        grant_any;
  logic        grant_port;
  logic [2:0]  oper_sel;
  logic [31:0] alu_result;
  logic        alu_zero;

  sr_alu u_alu (
    .srcA   (opa_q),
    .srcB   (opb_q),
    .oper   (op_q),
    .zero   (alu_zero),
    .result (alu_result)
  );

  // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    grant_any  = bus.req_valid_0 | bus.req_valid_1;
    grant_port = (bus.req_valid_0 & bus.req_valid_1) ? ~last_grant_q : bus.req_valid_1;
    oper_sel   = grant_port ? bus.req_oper_1 : bus.req_oper_0;
  end

  // Request ready is combinational in IDLE; forced low while reset is held.
  always_comb begin
    bus.req_ready_0 = ~rst & (state_q == SR_ARB_IDLE) & grant_any & ~grant_port;
    bus.req_ready_1 = ~rst & (state_q == SR_ARB_IDLE) & grant_any &  grant_port;
    bus.rsp_valid_0 = rsp_valid_0_q;
    bus.rsp_valid_1 = rsp_valid_1_q;
    bus.rsp_result  = rsp_result_q;
    bus.rsp_zero    = rsp_zero_q;
  end

  // FSM next-state and datapath capture.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    op_d          = op_q;
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_valid_0_d = rsp_valid_0_q;
    rsp_valid_1_d = rsp_valid_1_q;
    case (state_q)
      SR_ARB_IDLE: begin
        if (grant_any) begin
          opa_d        = grant_port ? bus.req_srcA_1 : bus.req_srcA_0;
          opb_d        = grant_port ? bus.req_srcB_1 : bus.req_srcB_0;
          op_d         = oper_sel;
          owner_d      = grant_port;
          last_grant_d = grant_port;
          cnt_d        = (oper_sel == ALU_MUL) ? MUL_CNT : '0;
          state_d      = SR_ARB_EXEC;
        end
      end
      SR_ARB_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d  = alu_result;
          rsp_zero_d    = alu_zero;
          rsp_valid_0_d = ~owner_q;
          rsp_valid_1_d =  owner_q;
          state_d       = SR_ARB_RESP;
        end
      end
      SR_ARB_RESP: begin
        if (owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0) begin
          rsp_valid_0_d = 1'b0;
          rsp_valid_1_d = 1'b0;
          state_d       = SR_ARB_IDLE;
        end
      end
      default: state_d = SR_ARB_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SR_ARB_IDLE;
      last_grant_q  <= RR_INIT;
      owner_q       <= 1'b0;
      cnt_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      op_q          <= '0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      op_q          <= op_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_valid_0_q <= rsp_valid_0_d;
      rsp_valid_1_q <= rsp_valid_1_d;
    end
  end

endmodule

// File: tb/tb_sr_alu_arb.sv
// Directed bench for sr_alu_arb: transaction-level model checked every cycle,
// plus hand-computed result/latency expectations for each scenario.
module tb_sr_alu_arb;
  import sr_alu_arb_pkg::*;

  localparam int unsigned LAT = 3;
  localparam bit          RRI = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sr_alu_arb_if bus ();

  sr_alu_arb #(.MUL_LAT(LAT), .RR_INIT(RRI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    logic [63:0] prod;
    case (op)
      3'd1: return a | b;
      3'd2: return a / (32'd1 << (b % 32));
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a + ~b + 32'd1;
      3'd5: begin prod = 64'(a) * 64'(b); return prod[31:0]; end
      default: return a + b;
    endcase
  endfunction

  // Which port should win right now: -1 when nobody asks.
  function automatic int pick(input logic v0, input logic v1, input bit last);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (v0 && v1)  return last ? 0 : 1;
    return -1;
  endfunction

  // phase: 0 free, 1 computing, 2 presenting response
  int          m_phase = 0;
  int          m_wait  = 0;
  bit          m_last  = RRI;
  int          m_owner = 0;
  logic [31:0] m_res   = '0;
  int          m_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_last  = RRI;
      m_owner = 0;
      m_res   = '0;
    end else begin
      case (m_phase)
        0: begin
          m_p = pick(bus.req_valid_0, bus.req_valid_1, m_last);
          if (m_p >= 0) begin
            if (m_p == 0) begin
              m_res  = ref_alu(bus.req_srcA_0, bus.req_srcB_0, bus.req_oper_0);
              m_wait = ((bus.req_oper_0 == 3'd5) ? int'(LAT) : 0) + 1;
            end else begin
              m_res  = ref_alu(bus.req_srcA_1, bus.req_srcB_1, bus.req_oper_1);
              m_wait = ((bus.req_oper_1 == 3'd5) ? int'(LAT) : 0) + 1;
            end
            m_owner = m_p;
            m_last  = (m_p == 1);
            m_phase = 1;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) m_phase = 2;
        end
        default: begin
          if ((m_owner == 0) ? bus.rsp_ready_0 : bus.rsp_ready_1) m_phase = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int p;
    logic e_r0, e_r1, e_v0, e_v1;
    p    = pick(bus.req_valid_0, bus.req_valid_1, m_last);
    e_r0 = !rst && m_phase == 0 && p == 0;
    e_r1 = !rst && m_phase == 0 && p == 1;
    e_v0 = !rst && m_phase == 2 && m_owner == 0;
    e_v1 = !rst && m_phase == 2 && m_owner == 1;
    chk("m_req_ready_0", 32'(bus.req_ready_0), 32'(e_r0));
    chk("m_req_ready_1", 32'(bus.req_ready_1), 32'(e_r1));
    chk("m_rsp_valid_0", 32'(bus.rsp_valid_0), 32'(e_v0));
    chk("m_rsp_valid_1", 32'(bus.rsp_valid_1), 32'(e_v1));
    if (rst) begin
      chk("m_rsp_result_rst", bus.rsp_result, 32'd0);
      chk("m_rsp_zero_rst", 32'(bus.rsp_zero), 32'd0);
    end else if (m_phase == 2) begin
      chk("m_rsp_result", bus.rsp_result, m_res);
      chk("m_rsp_zero", 32'(bus.rsp_zero), 32'(m_res == 32'd0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] op);
    if (p == 0) begin
      bus.req_valid_0 = v; bus.req_srcA_0 = a; bus.req_srcB_0 = b; bus.req_oper_0 = op;
    end else begin
      bus.req_valid_1 = v; bus.req_srcA_1 = a; bus.req_srcB_1 = b; bus.req_oper_1 = op;
    end
  endtask

  task automatic wait_ready(input int p, output int t0);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.req_ready_0 : bus.req_ready_1) seen = 1;
    end
    t0 = cyc;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout port%0d: got no req_ready expected req_ready=1", p);
    end
  endtask

  task automatic drop(input int p);
    @(posedge clk); #1;
    if (p == 0) bus.req_valid_0 = 1'b0; else bus.req_valid_1 = 1'b0;
  endtask

  task automatic wait_rsp(input int p, input int t0, input int lat,
                          input logic [31:0] res, input logic zero);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL rsp_timeout port%0d: got no rsp_valid expected rsp_valid=1", p);
    end else begin
      chk("latency", 32'(cyc - t0), 32'(lat));
      chk("result", bus.rsp_result, res);
      chk("zero", 32'(bus.rsp_zero), 32'(zero));
    end
  endtask

  task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input int lat,
                        input logic [31:0] res, input logic zero);
    int t0;
    @(posedge clk); #1;
    set_req(p, 1'b1, a, b, op);
    wait_ready(p, t0);
    drop(p);
    wait_rsp(p, t0, lat, res, zero);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    bus.rsp_ready_0 = 1'b1;
    bus.rsp_ready_1 = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_result", bus.rsp_result, 32'd0);
    chk("reset_valid0", 32'(bus.rsp_valid_0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Tie after reset: port 0 first, then the held port 1 request.
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'd9, 32'd9, ALU_SUB);
    set_req(1, 1'b1, 32'h0000_00F0, 32'h0000_000F, ALU_OR);
    wait_ready(0, t0);
    chk("tie1_ready1_low", 32'(bus.req_ready_1), 32'd0);
    drop(0);
    wait_rsp(0, t0, 2, 32'd0, 1'b1);
    wait_ready(1, t0);
    drop(1);
    wait_rsp(1, t0, 2, 32'h0000_00FF, 1'b0);

    // Port 0 alone: ADD 7+5.
    run_op(0, 32'd7, 32'd5, ALU_ADD, 2, 32'd12, 1'b0);

    // Second tie: port 0 served last, so port 1 goes first.
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'd100, 32'd23, ALU_ADD);
    set_req(1, 1'b1, 32'd5, 32'd7, ALU_SUB);
    wait_ready(1, t0);
    chk("tie2_ready0_low", 32'(bus.req_ready_0), 32'd0);
    drop(1);
    wait_rsp(1, t0, 2, 32'hFFFF_FFFE, 1'b0);
    wait_ready(0, t0);
    drop(0);
    wait_rsp(0, t0, 2, 32'd123, 1'b0);

    // Multiply stall on port 1, then a plain ADD.
    run_op(1, 32'h0001_0000, 32'h0001_0000, ALU_MUL, 2 + int'(LAT), 32'd0, 1'b1);
    run_op(1, 32'd2, 32'd3, ALU_ADD, 2, 32'd5, 1'b0);
    run_op(0, 32'd6, 32'd7, ALU_MUL, 2 + int'(LAT), 32'd42, 1'b0);

    // Response stall on port 0 while port 1 waits.
    @(posedge clk); #1;
    bus.rsp_ready_0 = 1'b0;
    set_req(0, 1'b1, 32'd3, 32'd4, ALU_ADD);
    wait_ready(0, t0);
    drop(0);
    set_req(1, 1'b1, 32'd10, 32'd20, ALU_ADD);
    wait_rsp(0, t0, 2, 32'd7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_result", bus.rsp_result, 32'd7);
      chk("stall_ready1", 32'(bus.req_ready_1), 32'd0);
      chk("stall_valid0", 32'(bus.rsp_valid_0), 32'd1);
    end
    @(posedge clk); #1;
    bus.rsp_ready_0 = 1'b1;
    @(negedge clk);
    chk("release_ready1_same", 32'(bus.req_ready_1), 32'd0);
    @(negedge clk);
    chk("release_ready1_next", 32'(bus.req_ready_1), 32'd1);
    t0 = cyc;
    drop(1);
    wait_rsp(1, t0, 2, 32'd30, 1'b0);

    // Shift and unsigned compare boundaries.
    run_op(0, 32'h8000_0000, 32'd33, ALU_SRL, 2, 32'h4000_0000, 1'b0);
    run_op(0, 32'hFFFF_FFFF, 32'd1, ALU_SLTU, 2, 32'd0, 1'b1);
    run_op(1, 32'd1, 32'hFFFF_FFFF, ALU_SLTU, 2, 32'd1, 1'b0);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'd6, 32'd7, ALU_MUL);
    wait_ready(0, t0);
    drop(0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_ADD);
    rst = 1'b1;
    #1;
    chk("abort_result", bus.rsp_result, 32'd0);
    chk("abort_zero", 32'(bus.rsp_zero), 32'd0);
    chk("abort_ready0", 32'(bus.req_ready_0), 32'd0);
    chk("abort_valid0", 32'(bus.rsp_valid_0), 32'd0);
    chk("abort_valid1", 32'(bus.rsp_valid_1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready(0, t0);
    drop(0);
    wait_rsp(0, t0, 2, 32'd2, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
